// File: rtl/spi_packet_tx_if.sv
// Interface bundling the packet handshake and the SPI-side outputs of spi_packet_tx.
// WIDTH must equal NUM_TRACKS*PACKET_SIZE of the transmitter it is bound to.
interface spi_packet_tx_if #(
   parameter int WIDTH = 24
);
   logic [WIDTH-1:0] packet;
   logic             valid;
   logic             ready;
   logic             cs;
   logic             sck;
   logic             sdi;
   logic             done;

   // master: packet source and SPI observer; slave: the transmitter itself
   modport master (output packet, valid, input ready, cs, sck, sdi, done);
   modport slave  (input packet, valid, output ready, cs, sck, sdi, done);
endinterface

// File: rtl/spi_packet_tx.sv
// spi_packet_tx: serialises one NUM_TRACKS*PACKET_SIZE-bit packet per handshake
// onto sdi under frame strobe cs, with sck idle low and data stable while sck is high.
// Optional build macro SPI_TX_LSB_FIRST_EN: send bit 0 first instead of bit N-1.
// Handshake: a packet is taken at a posedge where valid && ready; ready is low for
// the whole frame plus the inter-frame gap, and packet/valid are ignored meanwhile.
module spi_packet_tx #(
   parameter int NUM_TRACKS  = 1,
   parameter int PACKET_SIZE = 24,
   parameter int SCK_DIV     = 2
) (
   input  logic           clk,
   input  logic           reset,
   spi_packet_tx_if.slave bus,
   output logic [2:0]     dbg_state
);
   localparam int N     = NUM_TRACKS * PACKET_SIZE;
   localparam int DIV_W = $clog2(SCK_DIV + 1);
   localparam int BIT_W = $clog2(N + 1);

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      HOLD = 3'd3,
      GAP  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d, bit_inc;
   logic [N-1:0]     sh_q, sh_d, sh_next;
   logic             cs_q, cs_d;
   logic             sck_q, sck_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;

   // The outgoing bit always sits at the shift-register end, so sdi is a
   // register output that cannot be disturbed by packet changes mid-frame.
`ifdef SPI_TX_LSB_FIRST_EN
   assign sh_next = sh_q >> 1;
   assign bus.sdi = sh_q[0];
`else
   assign sh_next = sh_q << 1;
   assign bus.sdi = sh_q[N-1];
`endif

   assign bit_inc   = bit_q + BIT_ONE;
   assign bus.cs    = cs_q;
   assign bus.sck   = sck_q;
   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign dbg_state = state_q;

   // Next-state and next-output logic; every phase lasts SCK_DIV cycles.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      cs_d    = cs_q;
      sck_d   = sck_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!ready_q) begin
               // first cycle after reset or after the gap
               ready_d = 1'b1;
            end else if (bus.valid) begin
               sh_d    = bus.packet;
               ready_d = 1'b0;
               cs_d    = 1'b1;
               bit_d   = '0;
               div_d   = DIV_LOAD;
               state_d = LO;
            end
         end
         LO: begin
            if (div_q == '0) begin
               sck_d   = 1'b1;
               div_d   = DIV_LOAD;
               state_d = HI;
            end else begin
               div_d = div_q - DIV_ONE;
            end
         end
         HI: begin
            if (div_q == '0) begin
               sck_d = 1'b0;
               div_d = DIV_LOAD;
               bit_d = bit_inc;
               if (bit_inc < BIT_LAST) begin
                  sh_d    = sh_next;
                  state_d = LO;
               end else begin
                  state_d = HOLD;
               end
            end else begin
               div_d = div_q - DIV_ONE;
            end
         end
         HOLD: begin
            if (div_q == '0) begin
               cs_d    = 1'b0;
               done_d  = 1'b1;
               div_d   = DIV_LOAD;
               state_d = GAP;
            end else begin
               div_d = div_q - DIV_ONE;
            end
         end
         GAP: begin
            if (div_q == '0) begin
               state_d = IDLE;
            end else begin
               div_d = div_q - DIV_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         cs_q    <= 1'b0;
         sck_q   <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         cs_q    <= cs_d;
         sck_q   <= sck_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_spi_packet_tx.sv
// Bench for spi_packet_tx: three instances (24 bits / div 2, 48 bits / div 2,
// 24 bits / div 1) observed by a receiver-style monitor that samples sdi on sck rises.
module tb_spi_packet_tx;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_packet_tx_if #(.WIDTH(24)) bus_a ();
   spi_packet_tx_if #(.WIDTH(48)) bus_b ();
   spi_packet_tx_if #(.WIDTH(24)) bus_c ();
   logic [2:0] st_a, st_b, st_c;

   spi_packet_tx #(.NUM_TRACKS(1), .PACKET_SIZE(24), .SCK_DIV(2)) dut_a (
      .clk(clk), .reset(rst_n), .bus(bus_a), .dbg_state(st_a));
   spi_packet_tx #(.NUM_TRACKS(2), .PACKET_SIZE(24), .SCK_DIV(2)) dut_b (
      .clk(clk), .reset(rst_n), .bus(bus_b), .dbg_state(st_b));
   spi_packet_tx #(.NUM_TRACKS(1), .PACKET_SIZE(24), .SCK_DIV(1)) dut_c (
      .clk(clk), .reset(rst_n), .bus(bus_c), .dbg_state(st_c));

   int checks = 0;
   int errors = 0;

   // receiver-side observation per instance
   logic [63:0] cap[3];
   logic [63:0] last_word[3];
   int          bits[3], cslen[3], last_bits[3], last_len[3];
   int          frames[3], dones[3], viol[3];
   logic        psck[3], pcs[3], psdi[3];
   logic [63:0] exp_q[$];

   // ---------------- reference model ----------------
   function automatic int n_of(input int i);
      return (i == 1) ? 48 : 24;
   endfunction

   function automatic int d_of(input int i);
      return (i == 2) ? 1 : 2;
   endfunction

   function automatic int cs_exp(input int i);
      return 2 * n_of(i) * d_of(i) + d_of(i);
   endfunction

   function automatic int ready_exp(input int i);
      return cs_exp(i) + d_of(i) + 1;
   endfunction

   // word a receiver builds by shifting sampled bits in from the right
   function automatic logic [63:0] sent_order(input logic [63:0] p, input int n);
      logic [63:0] r;
      r = '0;
`ifdef SPI_TX_LSB_FIRST_EN
      for (int k = 0; k < n; k++) r[k] = p[n-1-k];
`else
      for (int k = 0; k < n; k++) r[k] = p[k];
`endif
      return r;
   endfunction

   function automatic logic rdy(input int i);
      case (i)
         0: return bus_a.ready;
         1: return bus_b.ready;
         default: return bus_c.ready;
      endcase
   endfunction

   // ---------------- monitor ----------------
   task automatic mon(input int i, input logic cs_v, input logic sck_v, input logic sdi_v,
                      input logic done_v, input logic ready_v);
      if (!rst_n) begin
         cap[i] = '0; bits[i] = 0; cslen[i] = 0;
      end else begin
         if (cs_v) cslen[i]++;
         if (sck_v && !psck[i]) begin
            cap[i] = {cap[i][62:0], sdi_v};
            bits[i]++;
         end
         if (sck_v && psck[i] && (sdi_v !== psdi[i])) viol[i]++;
         if (cs_v && ready_v) viol[i]++;
         if (sck_v && !cs_v) viol[i]++;
         if (done_v) begin
            dones[i]++;
            if (!(!cs_v && pcs[i])) viol[i]++;
         end
         if (!cs_v && pcs[i]) begin
            last_word[i] = cap[i]; last_bits[i] = bits[i]; last_len[i] = cslen[i];
            frames[i]++;
            cap[i] = '0; bits[i] = 0; cslen[i] = 0;
         end
      end
      psck[i] = sck_v; pcs[i] = cs_v; psdi[i] = sdi_v;
   endtask

   always @(negedge clk) begin
      mon(0, bus_a.cs, bus_a.sck, bus_a.sdi, bus_a.done, bus_a.ready);
      mon(1, bus_b.cs, bus_b.sck, bus_b.sdi, bus_b.done, bus_b.ready);
      mon(2, bus_c.cs, bus_c.sck, bus_c.sdi, bus_c.done, bus_c.ready);
   end

   // ---------------- drivers ----------------
   task automatic drive(input int i, input logic [63:0] p, input logic v);
      case (i)
         0: begin bus_a.packet = p[23:0]; bus_a.valid = v; end
         1: begin bus_b.packet = p[47:0]; bus_b.valid = v; end
         default: begin bus_c.packet = p[23:0]; bus_c.valid = v; end
      endcase
   endtask

   // waits for ready, presents the packet and returns just after the accepting edge
   task automatic handshake(input int i, input logic [63:0] p, input bit hold, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (rdy(i)) begin
            drive(i, p, 1'b1);
            @(posedge clk);
            #1;
            if (!hold) drive(i, p, 1'b0);
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL handshake dut%0d: ready=0, required 1 within 3000 cycles", i);
      end
   endtask

   task automatic wait_frame(input int i, input int f0);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         #1;
         if (frames[i] > f0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL frame_timeout dut%0d: frames=%0d, required >%0d", i, frames[i], f0);
      end
   endtask

   task automatic wait_bits(input int i, input int n);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         #1;
         if (bits[i] >= n) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL bits_timeout dut%0d: bits=%0d, required %0d", i, bits[i], n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, '0, 1'b0); drive(1, '0, 1'b0); drive(2, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus_a.cs, bus_a.sck, bus_a.sdi, bus_a.ready, bus_a.done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: cs,sck,sdi,ready,done=%b, required 00000",
                  {bus_a.cs, bus_a.sck, bus_a.sdi, bus_a.ready, bus_a.done});
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      checks++;
      if ({bus_a.ready, bus_b.ready, bus_c.ready} !== 3'b000) begin
         errors++;
         $display("FAIL ready_after_release: ready=%b, required 000",
                  {bus_a.ready, bus_b.ready, bus_c.ready});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus_a.ready, bus_b.ready, bus_c.ready} !== 3'b111) begin
         errors++;
         $display("FAIL ready_first_edge: ready=%b, required 111",
                  {bus_a.ready, bus_b.ready, bus_c.ready});
      end
   endtask

   task automatic test_single_frames();
      logic [63:0] pk[3];
      pk[0] = 64'h0114FF;
      pk[1] = 64'h0114FF0217FF;
      pk[2] = 64'h000001;
      for (int i = 0; i < 3; i++) begin
         int f0, dn, lat;
         bit ok;
         f0 = frames[i]; dn = dones[i];
         handshake(i, pk[i], 1'b0, ok);
         lat = 0;
         for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (rdy(i)) break;
         end
         wait_frame(i, f0);
         checks++;
         if (last_word[i] !== sent_order(pk[i], n_of(i))) begin
            errors++;
            $display("FAIL single_word dut%0d: got %h, required %h", i, last_word[i],
                     sent_order(pk[i], n_of(i)));
         end
         checks++;
         if (last_bits[i] != n_of(i)) begin
            errors++;
            $display("FAIL single_sck_rises dut%0d: got %0d, required %0d", i, last_bits[i], n_of(i));
         end
         checks++;
         if (last_len[i] != cs_exp(i)) begin
            errors++;
            $display("FAIL single_cs_len dut%0d: got %0d, required %0d", i, last_len[i], cs_exp(i));
         end
         checks++;
         if (lat != ready_exp(i)) begin
            errors++;
            $display("FAIL single_ready_latency dut%0d: got %0d, required %0d", i, lat, ready_exp(i));
         end
         checks++;
         if (dones[i] != dn + 1) begin
            errors++;
            $display("FAIL single_done_count dut%0d: got %0d, required %0d", i, dones[i] - dn, 1);
         end
      end
   endtask

   task automatic test_isolation();
      int  f0;
      bit  ok;
      logic [63:0] e;
      f0 = frames[0];
      handshake(0, 64'h0114FF, 1'b1, ok);
      exp_q.push_back(sent_order(64'h0114FF, 24));
      wait_bits(0, 5);
      drive(0, 64'hABCDEF, 1'b1);
      @(negedge clk);
      checks++;
      if (bus_a.ready !== 1'b0) begin
         errors++;
         $display("FAIL isolation_ready_mid: got %b, required 0", bus_a.ready);
      end
      handshake(0, 64'hABCDEF, 1'b0, ok);
      exp_q.push_back(sent_order(64'hABCDEF, 24));
      checks++;
      if (frames[0] != f0 + 1) begin
         errors++;
         $display("FAIL isolation_order: frames done=%0d, required %0d", frames[0] - f0, 1);
      end
      e = exp_q.pop_front();
      checks++;
      if (last_word[0] !== e) begin
         errors++;
         $display("FAIL isolation_frame1: got %h, required %h", last_word[0], e);
      end
      wait_frame(0, f0 + 1);
      e = exp_q.pop_front();
      checks++;
      if (last_word[0] !== e) begin
         errors++;
         $display("FAIL isolation_frame2: got %h, required %h", last_word[0], e);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i += 2) begin
         int  f0;
         bit  ok;
         logic [63:0] p, e;
         f0 = frames[i];
         for (int j = 0; j < 5; j++) begin
            p = {40'b0, 24'($urandom)};
            handshake(i, p, 1'b1, ok);
            exp_q.push_back(sent_order(p, 24));
            if (j > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (last_word[i] !== e) begin
                  errors++;
                  $display("FAIL b2b_word dut%0d frame %0d: got %h, required %h", i, j - 1,
                           last_word[i], e);
               end
            end
         end
         drive(i, '0, 1'b0);
         wait_frame(i, f0 + 4);
         e = exp_q.pop_front();
         checks++;
         if (last_word[i] !== e) begin
            errors++;
            $display("FAIL b2b_last dut%0d: got %h, required %h", i, last_word[i], e);
         end
         checks++;
         if (last_len[i] != cs_exp(i)) begin
            errors++;
            $display("FAIL b2b_cs_len dut%0d: got %0d, required %0d", i, last_len[i], cs_exp(i));
         end
      end
   endtask

   task automatic test_reset_mid();
      int  f0, dn;
      bit  ok;
      f0 = frames[0]; dn = dones[0];
      handshake(0, 64'h0114FF, 1'b0, ok);
      wait_bits(0, 10);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_a.cs, bus_a.sck, bus_a.sdi, bus_a.ready, bus_a.done} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_outputs: cs,sck,sdi,ready,done=%b, required 00000",
                  {bus_a.cs, bus_a.sck, bus_a.sdi, bus_a.ready, bus_a.done});
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dones[0] != dn || frames[0] != f0) begin
         errors++;
         $display("FAIL midreset_no_done: done pulses=%0d frames=%0d, required 0 and 0",
                  dones[0] - dn, frames[0] - f0);
      end
      handshake(0, 64'h0114FF, 1'b0, ok);
      wait_frame(0, f0);
      checks++;
      if (last_word[0] !== sent_order(64'h0114FF, 24) || last_bits[0] != 24) begin
         errors++;
         $display("FAIL midreset_resend: got %h/%0d bits, required %h/24", last_word[0],
                  last_bits[0], sent_order(64'h0114FF, 24));
      end
   endtask

   task automatic test_protocol();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (viol[i] != 0) begin
            errors++;
            $display("FAIL protocol dut%0d: violations=%0d, required 0", i, viol[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         cap[i] = '0; last_word[i] = '0; bits[i] = 0; cslen[i] = 0; last_bits[i] = 0;
         last_len[i] = 0; frames[i] = 0; dones[i] = 0; viol[i] = 0;
         psck[i] = 1'b0; pcs[i] = 1'b0; psdi[i] = 1'b0;
      end
      test_reset();
      test_single_frames();
      test_isolation();
      test_back_to_back();
      test_reset_mid();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      checks++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
